// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared hold-level encodings, address width and controller state encodings
// for the pipeline hold/flush controller and any other hold-request arbiters.
package pipe_hold_ctrl_pkg;

    localparam int HOLD_FLAG_W     = 3;
    localparam int INST_ADDR_WIDTH = 32;

    typedef logic [HOLD_FLAG_W-1:0] hold_flag_t;

    // Stages compare the bus with >=, so a numerically larger level implies
    // every effect of the smaller ones.
    localparam hold_flag_t HOLD_NONE = 3'd0;
    localparam hold_flag_t HOLD_PC   = 3'd1;
    localparam hold_flag_t HOLD_IF   = 3'd2;
    localparam hold_flag_t HOLD_ID   = 3'd3;

    // Number of hold sources merged by the controller
    localparam int HOLD_REQ_N = 5;

    typedef enum logic {
        PIPE_CTRL_RUN   = 1'b0,
        PIPE_CTRL_FLUSH = 1'b1
    } pipe_ctrl_state_e;

    // A request contributes its level when active and nothing otherwise
    function automatic hold_flag_t hold_level(input logic req, input hold_flag_t lvl);
        return req ? lvl : HOLD_NONE;
    endfunction

endpackage

// File: rtl/pipe_hold_ctrl_if.sv
// Request/response bundle between the pipeline stages and the hold controller.
// The master side raises hold requests; the slave side is the controller.
interface pipe_hold_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    import pipe_hold_ctrl_pkg::*;

    logic                       jump_flag_i;
    logic [INST_ADDR_WIDTH-1:0] jump_addr_i;
    logic                       ex_busy_i;
    logic                       clint_hold_i;
    logic                       ifu_stall_i;
    logic                       stall_cnt_clr_i;

    hold_flag_t                 hold_flag_o;
    logic                       jump_flag_o;
    logic [INST_ADDR_WIDTH-1:0] jump_addr_o;
    logic                       wdog_err_o;
    logic [CNT_WIDTH-1:0]       stall_cnt_o;

    modport master (
        output jump_flag_i, jump_addr_i, ex_busy_i, clint_hold_i,
               ifu_stall_i, stall_cnt_clr_i,
        input  hold_flag_o, jump_flag_o, jump_addr_o, wdog_err_o, stall_cnt_o
    );

    modport slave (
        input  jump_flag_i, jump_addr_i, ex_busy_i, clint_hold_i,
               ifu_stall_i, stall_cnt_clr_i,
        output hold_flag_o, jump_flag_o, jump_addr_o, wdog_err_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_hold_ctrl_hold_max.sv
// Combinational max-of-N reducer for hold levels; because stages act on
// hold >= level, the largest request is the one that must win.
module hold_max #(
    parameter int N = 2,
    parameter int W = 3
) (
    input  logic [N-1:0][W-1:0] req_i,
    output logic [W-1:0]        max_o
);

    // Linear scan keeping the largest level seen so far
    always_comb begin
        max_o = '0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i] > max_o) begin
                max_o = req_i[i];
            end
        end
    end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Central pipeline hold/flush controller: merges hold requests into one
// hold level, passes redirects through to the PC, stretches each redirect by
// a refill window, counts stalled cycles and watches for a stuck EX unit.
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int FLUSH_EXTRA = 1,
    parameter int WDOG_CYCLES = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hold_ctrl_if.slave  bus
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_EXTRA);
    localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_CYCLES);

    pipe_ctrl_state_e                  state_q, state_d;
    logic [2:0]                        flush_cnt_q, flush_cnt_d;
    logic [7:0]                        wdog_cnt_q, wdog_cnt_d;
    logic                              wdog_err_q, wdog_err_d;
    logic [CNT_WIDTH-1:0]              stall_cnt_q, stall_cnt_d;

    logic [HOLD_REQ_N-1:0][HOLD_FLAG_W-1:0] hold_req;
    hold_flag_t                        hold_flag;

    // Collect every live request, plus the refill window, at its hold level
    always_comb begin
        hold_req    = '0;
        hold_req[0] = hold_level(bus.jump_flag_i, HOLD_ID);
        hold_req[1] = hold_level(bus.clint_hold_i, HOLD_ID);
        hold_req[2] = hold_level(bus.ex_busy_i, HOLD_ID);
        hold_req[3] = hold_level(bus.ifu_stall_i, HOLD_PC);
        hold_req[4] = hold_level(state_q == PIPE_CTRL_FLUSH, HOLD_IF);
    end

    hold_max #(
        .N (HOLD_REQ_N),
        .W (HOLD_FLAG_W)
    ) u_hold_max (
        .req_i (hold_req),
        .max_o (hold_flag)
    );

    // Refill window: a redirect opens it, a newer redirect restarts it
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            PIPE_CTRL_RUN: begin
                if (bus.jump_flag_i && (FLUSH_EXTRA > 0)) begin
                    state_d     = PIPE_CTRL_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            PIPE_CTRL_FLUSH: begin
                if (bus.jump_flag_i) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q <= 3'd1) begin
                    state_d     = PIPE_CTRL_RUN;
                    flush_cnt_d = 3'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d     = PIPE_CTRL_RUN;
                flush_cnt_d = 3'd0;
            end
        endcase
    end

    // Watchdog tracks the current unbroken busy run and latches a timeout
    always_comb begin
        wdog_cnt_d = 8'd0;
        if (bus.ex_busy_i) begin
            wdog_cnt_d = (wdog_cnt_q == WDOG_LIMIT) ? WDOG_LIMIT : wdog_cnt_q + 8'd1;
        end
        wdog_err_d = wdog_err_q | (wdog_cnt_d == WDOG_LIMIT);
    end

    // Stall counter counts held cycles; a clear request overrides counting
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.stall_cnt_clr_i) begin
            stall_cnt_d = '0;
        end else if (hold_flag != HOLD_NONE) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers, all cleared immediately by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PIPE_CTRL_RUN;
            flush_cnt_q <= 3'd0;
            wdog_cnt_q  <= 8'd0;
            wdog_err_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_err_q  <= wdog_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.hold_flag_o = hold_flag;
    assign bus.jump_flag_o = bus.jump_flag_i;
    assign bus.jump_addr_o = bus.jump_addr_i;
    assign bus.wdog_err_o  = wdog_err_q;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl: two instances with different refill, watchdog
// and counter widths share one directed stimulus stream, each checked every
// cycle against its own behavioural model plus hand-computed pin values.
module tb_pipe_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        busy = 1'b0;
    logic        clint = 1'b0;
    logic        ifu = 1'b0;
    logic        clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    localparam int FE_A = 2, WD_A = 64, CW_A = 32;
    localparam int FE_B = 5, WD_B = 4,  CW_B = 4;

    always #5 clk = ~clk;

    pipe_hold_ctrl_if #(.CNT_WIDTH(CW_A)) if_a ();
    pipe_hold_ctrl_if #(.CNT_WIDTH(CW_B)) if_b ();

    assign if_a.jump_flag_i     = jump;
    assign if_a.jump_addr_i     = addr;
    assign if_a.ex_busy_i       = busy;
    assign if_a.clint_hold_i    = clint;
    assign if_a.ifu_stall_i     = ifu;
    assign if_a.stall_cnt_clr_i = clr;
    assign if_b.jump_flag_i     = jump;
    assign if_b.jump_addr_i     = addr;
    assign if_b.ex_busy_i       = busy;
    assign if_b.clint_hold_i    = clint;
    assign if_b.ifu_stall_i     = ifu;
    assign if_b.stall_cnt_clr_i = clr;

    pipe_hold_ctrl #(.FLUSH_EXTRA(FE_A), .WDOG_CYCLES(WD_A), .CNT_WIDTH(CW_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    pipe_hold_ctrl #(.FLUSH_EXTRA(FE_B), .WDOG_CYCLES(WD_B), .CNT_WIDTH(CW_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    // Model state: remaining refill cycles, length of current busy run,
    // sticky timeout, and the stall count
    typedef struct {
        int     flush_left;
        int     busy_run;
        bit     err;
        longint cnt;
    } model_t;

    model_t m_a = '{0, 0, 1'b0, 0};
    model_t m_b = '{0, 0, 1'b0, 0};

    function automatic int model_hold(input model_t m, input bit j, input bit b,
                                      input bit c, input bit f);
        int lv[5];
        int h = 0;
        lv[0] = j ? 3 : 0;
        lv[1] = c ? 3 : 0;
        lv[2] = b ? 3 : 0;
        lv[3] = f ? 1 : 0;
        lv[4] = (m.flush_left > 0) ? 2 : 0;
        foreach (lv[i]) if (lv[i] > h) h = lv[i];
        return h;
    endfunction

    function automatic model_t model_step(input model_t m, input int fe, input int wd,
                                          input int cw, input bit j, input bit b,
                                          input bit c, input bit f, input bit cl);
        model_t r = m;
        int h = model_hold(m, j, b, c, f);
        if (j && fe > 0) r.flush_left = fe;
        else if (m.flush_left > 0) r.flush_left = m.flush_left - 1;
        if (b) r.busy_run = (m.busy_run < wd) ? m.busy_run + 1 : wd;
        else r.busy_run = 0;
        if (r.busy_run >= wd) r.err = 1'b1;
        if (cl) r.cnt = 0;
        else if (h != 0) r.cnt = (m.cnt + 1) % (longint'(1) << cw);
        return r;
    endfunction

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance both models on every edge; reset clears them at once
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_a = '{0, 0, 1'b0, 0};
            m_b = '{0, 0, 1'b0, 0};
        end else begin
            m_a = model_step(m_a, FE_A, WD_A, CW_A, jump, busy, clint, ifu, clr);
            m_b = model_step(m_b, FE_B, WD_B, CW_B, jump, busy, clint, ifu, clr);
        end
    end

    // Compare both instances against their models mid-cycle
    always @(negedge clk) begin
        check_output("cmp_hold_a", longint'(if_a.hold_flag_o), model_hold(m_a, jump, busy, clint, ifu));
        check_output("cmp_hold_b", longint'(if_b.hold_flag_o), model_hold(m_b, jump, busy, clint, ifu));
        check_output("cmp_jflag_a", longint'(if_a.jump_flag_o), longint'(jump));
        check_output("cmp_jaddr_b", longint'(if_b.jump_addr_o), longint'(addr));
        check_output("cmp_err_a", longint'(if_a.wdog_err_o), longint'(m_a.err));
        check_output("cmp_err_b", longint'(if_b.wdog_err_o), longint'(m_b.err));
        check_output("cmp_cnt_a", longint'(if_a.stall_cnt_o), m_a.cnt);
        check_output("cmp_cnt_b", longint'(if_b.stall_cnt_o), m_b.cnt);
    end

    // One cycle of stimulus, returning mid-cycle so outputs can be inspected
    task automatic apply_stimulus(input bit j, input logic [31:0] a, input bit b,
                                  input bit c, input bit f, input bit cl);
        @(posedge clk);
        #1;
        jump = j; addr = a; busy = b; clint = c; ifu = f; clr = cl;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 32'd0, 0, 0, 0, 0);
    endtask

    task automatic assert_reset();
        #2 rst = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    int hold_tbl[9] = '{3, 3, 3, 3, 3, 1, 1, 1, 0};

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Idle after reset
        idle(10);
        check_output("idle_hold_a", longint'(if_a.hold_flag_o), 0);
        check_output("idle_jflag", longint'(if_a.jump_flag_o), 0);
        check_output("idle_cnt_a", longint'(if_a.stall_cnt_o), 0);
        check_output("idle_err_a", longint'(if_a.wdog_err_o), 0);
        check_output("idle_cnt_b", longint'(if_b.stall_cnt_o), 0);

        // Single redirect
        apply_stimulus(1, 32'h0000_0100, 0, 0, 0, 0);
        check_output("j1_hold_c0", longint'(if_a.hold_flag_o), 3);
        check_output("j1_jflag_c0", longint'(if_a.jump_flag_o), 1);
        check_output("j1_addr_c0", longint'(if_a.jump_addr_o), 32'h100);
        idle(1);
        check_output("j1_hold_c1", longint'(if_a.hold_flag_o), 2);
        idle(1);
        check_output("j1_hold_c2", longint'(if_a.hold_flag_o), 2);
        idle(1);
        check_output("j1_hold_c3", longint'(if_a.hold_flag_o), 0);
        check_output("j1_cnt_a", longint'(if_a.stall_cnt_o), 3);
        check_output("j1_hold_b_c3", longint'(if_b.hold_flag_o), 2);
        idle(3);
        check_output("j1_hold_b_end", longint'(if_b.hold_flag_o), 0);
        check_output("j1_cnt_b", longint'(if_b.stall_cnt_o), 6);

        // Second redirect inside the first refill cycle
        apply_stimulus(0, 32'd0, 0, 0, 0, 1);
        apply_stimulus(1, 32'h0000_0100, 0, 0, 0, 0);
        apply_stimulus(1, 32'h0000_0200, 0, 0, 0, 0);
        check_output("j2_hold_c0", longint'(if_a.hold_flag_o), 3);
        check_output("j2_addr_c0", longint'(if_a.jump_addr_o), 32'h200);
        idle(1);
        check_output("j2_hold_c1", longint'(if_a.hold_flag_o), 2);
        idle(1);
        check_output("j2_hold_c2", longint'(if_a.hold_flag_o), 2);
        idle(1);
        check_output("j2_hold_c3", longint'(if_a.hold_flag_o), 0);
        check_output("j2_cnt_a", longint'(if_a.stall_cnt_o), 4);
        idle(3);
        check_output("j2_hold_b_end", longint'(if_b.hold_flag_o), 0);
        check_output("j2_cnt_b", longint'(if_b.stall_cnt_o), 7);

        // Busy overlapping a fetch stall
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(0, 32'd0, i < 5, 0, (i >= 2) && (i <= 7), 0);
            check_output($sformatf("busy_hold_c%0d", i), longint'(if_a.hold_flag_o), hold_tbl[i]);
        end
        check_output("busy_err_a", longint'(if_a.wdog_err_o), 0);
        check_output("busy_err_b", longint'(if_b.wdog_err_o), 1);

        // Watchdog timeout on the short-limit instance
        assert_reset();
        check_output("wd_rst_err_b", longint'(if_b.wdog_err_o), 0);
        release_reset();
        for (int i = 0; i < 4; i++) apply_stimulus(0, 32'd0, 1, 0, 0, 0);
        check_output("wd_err_b_c3", longint'(if_b.wdog_err_o), 0);
        idle(1);
        check_output("wd_err_b_c4", longint'(if_b.wdog_err_o), 1);
        idle(1);
        check_output("wd_err_b_sticky", longint'(if_b.wdog_err_o), 1);
        check_output("wd_err_a", longint'(if_a.wdog_err_o), 0);
        assert_reset();
        check_output("wd_clear_err_b", longint'(if_b.wdog_err_o), 0);
        release_reset();

        // Reset in the middle of a refill window
        apply_stimulus(1, 32'h0000_0300, 0, 0, 0, 0);
        idle(2);
        check_output("rf_hold_b_pre", longint'(if_b.hold_flag_o), 2);
        assert_reset();
        check_output("rf_hold_a_rst", longint'(if_a.hold_flag_o), 0);
        check_output("rf_hold_b_rst", longint'(if_b.hold_flag_o), 0);
        check_output("rf_cnt_a_rst", longint'(if_a.stall_cnt_o), 0);
        check_output("rf_cnt_b_rst", longint'(if_b.stall_cnt_o), 0);
        release_reset();
        check_output("rf_hold_b_post", longint'(if_b.hold_flag_o), 0);

        // Clear priority and counter wrap on the narrow instance
        apply_stimulus(0, 32'd0, 0, 1, 0, 1);
        for (int i = 0; i < 16; i++) apply_stimulus(0, 32'd0, 0, 1, 0, 0);
        idle(1);
        check_output("wrap_cnt_b", longint'(if_b.stall_cnt_o), 0);
        check_output("wrap_cnt_a", longint'(if_a.stall_cnt_o), 16);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
